mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and its data-memory port.
- Arbitrates between the two requesters and keeps one transaction outstanding at a time.
- Sequences a req/gnt/rvalid handshake to memory and returns a registered response with a one-cycle ready pulse to the winning requester.
- Sits between the pipelined core and the memory model. The core stalls its fetch and DM stages on a pending request until ready is seen.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width; wmask width is DATA_W/8
- TIMEOUT, 64, cycles waiting in WAIT_GNT plus WAIT_RSP before a bus error is forced; must be ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request, level-held until i_ready
- i_addr  in  ADDR_W  instruction address
- i_rdata  out  DATA_W  registered instruction data
- i_ready  out  1  one-cycle completion pulse for the instruction port
- d_req  in  1  data request, level-held until d_ready
- d_we  in  1  data write enable
- d_wmask  in  DATA_W/8  byte write mask
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  registered load data
- d_ready  out  1  one-cycle completion pulse for the data port
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_wmask  out  DATA_W/8  memory byte mask
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_gnt  in  1  memory accepted the request (sampled only in WAIT_GNT)
- mem_rvalid  in  1  response valid; acknowledges writes too (sampled only in WAIT_RSP)
- mem_rdata  in  DATA_W  response data
- err_clr  in  1  clears the sticky error flag
- bus_err  out  1  sticky timeout flag
- err_addr  out  ADDR_W  address of the first timed-out transaction

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0, including rdata registers, ready pulses, mem_* signals, bus_err and err_addr.
  - Reset mid-transaction aborts at the edge. mem_req drops the next cycle. A late mem_rvalid is ignored because the state is IDLE.
- States: IDLE, WAIT_GNT, WAIT_RSP, DONE.
- IDLE:
  - If any request is present, pick a winner and latch owner, we, wmask, addr and wdata into internal registers. Go to WAIT_GNT.
  - An instruction request always latches we=0 and wmask=0.
  - No request: stay in IDLE.
- WAIT_GNT:
  - mem_req=1; mem_* are driven from the latched registers and stay stable.
  - mem_gnt=1 moves to WAIT_RSP, with mem_req=0 from the next cycle.
- WAIT_RSP:
  - On mem_rvalid=1, capture mem_rdata into the owner's rdata register and go to DONE.
  - Write transactions also capture into d_rdata; the value is don't-care but is updated.
- DONE:
  - The owner's ready=1 for exactly this cycle; go to IDLE.
  - Requests are not sampled in DONE.
  - A requester must drop req at the edge where it sees ready. If req is still high in IDLE, it is a new request.
- Minimum latency: req seen in IDLE at cycle 0, gnt at cycle 1, rvalid at cycle 2, ready at cycle 3. Each back-to-back access costs 4 cycles.
- Non-owner: its rdata holds its old value and its ready stays 0.
- Default arbitration: fixed priority, data port wins when both requesters are present.
- Timeout counter:
  - Cleared on entry to WAIT_GNT and increments in WAIT_GNT and WAIT_RSP.
  - When it reaches TIMEOUT-1 with no completing event: go to DONE, owner rdata=0, ready pulses, bus_err=1.
  - err_addr is captured only if bus_err was 0 beforehand.
  - A completing gnt or rvalid in that same cycle takes priority over the timeout.
- Error clear: err_clr=1 clears bus_err in the next cycle. err_addr holds its value. A simultaneous new timeout wins and bus_err stays 1.
- Address and data are passed through unmodified; the arbiter does no alignment checking.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_owner register (reset value = instr) selects the winner when both requesters are present: the port not served last wins.
  - When only one requester is present it always wins.
  - last_owner updates on entry to DONE.
- Undefined: fixed data priority; the instruction port can starve while d_req is continuously high.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100. Memory gives gnt at cycle 1 and rvalid with rdata=0x00000013 at cycle 2. Expect mem_addr=0x100, mem_we=0, i_ready pulse at cycle 3, i_rdata=0x13, d_ready=0.
- Simultaneous requests: i_req=1 and d_req=1 (load 0x2000) in the same cycle. Expect the data transaction first (d_ready at cycle 3), then the instruction transaction (i_ready at cycle 7). Under MEM_ARB_RR_EN after reset, expect data first, then instruction.
- Write: d_we=1, d_wmask=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF, gnt delayed 3 cycles. Expect mem_req held high with stable mem_* for 4 cycles and d_ready one cycle after rvalid.
- Timeout: TIMEOUT=8, memory never asserts gnt. Expect i_ready pulse with i_rdata=0, bus_err=1, err_addr=i_addr. Then err_clr=1 gives bus_err=0 in the next cycle.
- Round-robin (MEM_ARB_RR_EN): both requests held continuously for 4 transactions. Expect owner order D,I,D,I. Without the macro, expect D,D,D,D.
- Reset in WAIT_RSP: assert reset, then mem_rvalid=1 one cycle later. Expect mem_req=0, no ready pulse, rdata registers=0 and state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch port and
//   the data port. One transaction is outstanding at a time and is run as
//   req/gnt/rvalid towards memory. The winner gets a registered response
//   and a one-cycle ready pulse.
//
//   Optional build macro MEM_ARB_RR_EN: round-robin choice when both ports
//   request together. Without it the data port always wins a tie.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_req/i_addr               instruction read request (held until i_ready)
//   i_rdata/i_ready            registered fetch data, completion pulse
//   d_req/d_we/d_wmask/d_addr/d_wdata   data request (held until d_ready)
//   d_rdata/d_ready            registered load data, completion pulse
//   mem_req/we/wmask/addr/wdata request towards memory
//   mem_gnt/mem_rvalid/mem_rdata        memory handshake and response
//   err_clr                    clears the sticky bus error
//   bus_err/err_addr           sticky timeout flag, first timed-out address
//
// FSM states
//   state      | meaning
//   S_IDLE     | no transaction; sample requests and latch the winner
//   S_WAIT_GNT | mem_req high, waiting for mem_gnt
//   S_WAIT_RSP | request accepted, waiting for mem_rvalid
//   S_DONE     | owner's ready pulses for this one cycle
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                err_clr,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam int MASK_W = DATA_W / 8;
  // Counter must hold TIMEOUT: a grant on the last allowed cycle carries
  // the count one past the limit into S_WAIT_RSP.
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_GNT = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state;
  logic              owner;
  logic              lat_we;
  logic [MASK_W-1:0] lat_wmask;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              pick_d;
  logic              tmo_hit;
  logic              tmo_fire;

`ifdef MEM_ARB_RR_EN
  logic last_owner;
  logic enter_done;

  // On a tie the port not served last wins; a lone requester always wins.
  assign pick_d     = d_req & (~i_req | (last_owner == OWN_I));
  assign enter_done = tmo_fire | ((state == S_WAIT_RSP) & mem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_I;
    end else if (enter_done) begin
      last_owner <= owner;
    end
  end
`else
  assign pick_d = d_req;
`endif

  assign tmo_hit = (tmo_cnt >= CNT_W'(TIMEOUT - 1));

  // A completing gnt/rvalid in the limit cycle beats the timeout.
  assign tmo_fire = tmo_hit &
                    (((state == S_WAIT_GNT) & ~mem_gnt) |
                     ((state == S_WAIT_RSP) & ~mem_rvalid));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= OWN_I;
      lat_we    <= 1'b0;
      lat_wmask <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      tmo_cnt   <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (err_clr) begin
        bus_err <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner <= pick_d;
            if (pick_d) begin
              lat_we    <= d_we;
              lat_wmask <= d_wmask;
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
            end else begin
              lat_we    <= 1'b0;
              lat_wmask <= '0;
              lat_addr  <= i_addr;
              lat_wdata <= '0;
            end
            tmo_cnt <= '0;
            state   <= S_WAIT_GNT;
          end
        end
        S_WAIT_GNT: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (mem_gnt) begin
            state <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (mem_rvalid) begin
            // Writes also land in d_rdata; the value is don't-care.
            if (owner == OWN_D) begin
              d_rdata <= mem_rdata;
            end else begin
              i_rdata <= mem_rdata;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Forced completion overrides the state update above. It also wins
      // over a simultaneous err_clr.
      if (tmo_fire) begin
        state <= S_DONE;
        if (owner == OWN_D) begin
          d_rdata <= '0;
        end else begin
          i_rdata <= '0;
        end
        bus_err <= 1'b1;
        if (!bus_err) begin
          err_addr <= lat_addr;
        end
      end
    end
  end

  assign mem_req   = (state == S_WAIT_GNT);
  assign mem_we    = lat_we & mem_req;
  assign mem_wmask = mem_req ? lat_wmask : '0;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign i_ready = (state == S_DONE) & (owner == OWN_I);
  assign d_ready = (state == S_DONE) & (owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives mem_port_arbiter (TIMEOUT=8) from both requester ports.
//   A memory responder has programmable gnt/rvalid delays. Expected
//   readiness, data and error state come from a transaction-level model:
//   a word-addressed reference memory, a winner rule and fixed latencies.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 8;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [MW-1:0] d_wmask;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [MW-1:0] mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err_clr;
  logic          bus_err;
  logic [AW-1:0] err_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
  );

  int checks = 0;
  int errors = 0;

  // responder controls
  int   gnt_dly = 0;
  int   rsp_dly = 0;
  bit   no_gnt = 1'b0;
  bit   mem_flush = 1'b0;
  bit   inject_rv = 1'b0;
  int   gcnt = 0;
  int   rcnt = 0;
  bit   pend = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] mem_array [logic [AW-1:0]];

  // reference model
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            rr_last;   // 0 = instruction served last, 1 = data
  logic [DW-1:0] exp_i_rd;
  logic [DW-1:0] exp_d_rd;
  bit            d_known;
  bit            exp_berr;
  logic [AW-1:0] exp_eaddr;

  function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] wd,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
  endfunction

  // Memory responder: acts 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (mem_flush) begin
      pend = 1'b0;
      gcnt = 0;
    end else if (inject_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_0BAD;
    end else if (pend) begin
      if (rcnt >= rsp_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
        pend       = 1'b0;
      end else begin
        rcnt++;
      end
    end else if (mem_req && !no_gnt) begin
      if (gcnt >= gnt_dly) begin
        mem_gnt = 1'b1;
        pend    = 1'b1;
        rcnt    = 0;
        gcnt    = 0;
        if (mem_we) begin
          mem_array[mem_addr] = merge(mem_array.exists(mem_addr) ?
                                      mem_array[mem_addr] : seed_val(mem_addr),
                                      mem_wdata, mem_wmask);
          pend_data = $urandom;
        end else begin
          pend_data = mem_array.exists(mem_addr) ? mem_array[mem_addr]
                                                 : seed_val(mem_addr);
        end
      end else begin
        gcnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_flush = 1'b1; inject_rv = 1'b0;
    i_req = 1'b0; d_req = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; mem_flush = 1'b0;
    rr_last = 1'b0; exp_i_rd = '0; exp_d_rd = '0; d_known = 1'b1;
    exp_berr = 1'b0; exp_eaddr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_i_ready"}, i_ready, 0);
    chk({tag, "_d_ready"}, d_ready, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask

  // One or two transactions presented together from IDLE.
  task automatic episode(input bit ri, input bit rd, input bit dwe,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd, input logic [MW-1:0] dm,
                         input int g, input int r, input bit nog, input bit clr_at_to);
    bit first_d;
    int t1, t2, ti, td, last, gwin;
    gnt_dly = g; rsp_dly = r; no_gnt = nog;
    first_d = (ri && rd) ? (RR_EN ? (rr_last == 1'b0) : 1'b1) : rd;
    t1   = nog ? TO + 1 : 3 + g + r;
    t2   = (ri && rd) ? 2 * t1 + 1 : -1;
    ti   = !ri ? -1 : ((rd && first_d) ? t2 : t1);
    td   = !rd ? -1 : ((ri && !first_d) ? t2 : t1);
    last = ((t2 > t1) ? t2 : t1) + 1;
    gwin = nog ? TO : g + 1;
    i_req = ri; i_addr = ia;
    d_req = rd; d_we = dwe; d_addr = da; d_wdata = dwd; d_wmask = dm;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (clr_at_to) err_clr = (c == t1 - 1);
      chk("i_ready", i_ready, c == ti);
      chk("d_ready", d_ready, c == td);
      if (c == ti) begin
        exp_i_rd = nog ? '0 : ref_read(ia);
        rr_last = 1'b0; i_req = 1'b0;
        if (nog) begin
          if (!exp_berr) exp_eaddr = ia;
          exp_berr = 1'b1;
        end
      end
      if (c == td) begin
        if (nog) begin
          exp_d_rd = '0; d_known = 1'b1;
          if (!exp_berr) exp_eaddr = da;
          exp_berr = 1'b1;
        end else if (dwe) begin
          ref_mem[da] = merge(ref_read(da), dwd, dm);
          d_known = 1'b0;
        end else begin
          exp_d_rd = ref_read(da); d_known = 1'b1;
        end
        rr_last = 1'b1; d_req = 1'b0;
      end
      chk("i_rdata", i_rdata, exp_i_rd);
      if (d_known) chk("d_rdata", d_rdata, exp_d_rd);
      chk("bus_err", bus_err, exp_berr);
      chk("err_addr", err_addr, exp_eaddr);
      for (int k = 0; k < 2; k++) begin
        if (k == 0 || (ri && rd)) begin
          int b;
          bit kd;
          b  = (k == 0) ? 0 : t1 + 1;
          kd = (k == 0) ? first_d : !first_d;
          if (c - b >= 1 && c - b <= gwin) begin
            chk("mem_req_hi", mem_req, 1);
            chk("mem_addr", mem_addr, kd ? da : ia);
            chk("mem_we", mem_we, kd ? dwe : 1'b0);
            chk("mem_wmask", mem_wmask, kd ? dm : 4'h0);
            if (kd) chk("mem_wdata", mem_wdata, dwd);
          end else if (c - b == gwin + 1) begin
            chk("mem_req_lo", mem_req, 0);
          end
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0; err_clr = 1'b0; no_gnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pool_a;
    int  nxt;
    bit  wd;
    bit  ri, rd;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wmask = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; err_clr = 1'b0;

    do_reset();
    chk_all_zero("reset");

    // single fetch
    mem_array[32'h100] = 32'h0000_0013;
    ref_mem[32'h100]   = 32'h0000_0013;
    episode(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_data", i_rdata, 32'h13);
    chk("fetch_no_d_ready", d_ready, 0);

    // simultaneous requests
    episode(1, 1, 0, 32'h104, 32'h2000, 0, 4'hF, 0, 0, 0, 0);

    // write with delayed grant, then read it back
    episode(0, 1, 1, 0, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 3, 0, 0, 0);
    episode(0, 1, 0, 0, 32'h2004, 0, 4'hF, 1, 2, 0, 0);
    chk("merge_readback", d_rdata, (seed_val(32'h2004) & 32'hFFFF_0000) | 32'h0000_BEEF);

    // timeout, second timeout with simultaneous clear, then clear
    episode(1, 0, 0, 32'h300, 0, 0, 0, 0, 0, 1, 0);
    chk("to_err_addr", err_addr, 32'h300);
    episode(0, 1, 0, 0, 32'h400, 0, 4'hF, 0, 0, 1, 1);
    chk("to2_bus_err", bus_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_berr = 1'b0;
    chk("clr_bus_err", bus_err, 0);
    chk("clr_err_addr", err_addr, 32'h300);

    // completing event on the last allowed cycle
    episode(1, 0, 0, 32'h108, 0, 0, 0, TO - 1, 0, 0, 0);
    episode(0, 1, 0, 0, 32'h10C, 0, 4'h3, 0, TO - 2, 0, 0);
    chk("edge_no_err", bus_err, 0);

    // both requests held for four transactions after reset
    do_reset();
    gnt_dly = 0; rsp_dly = 0;
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_wmask = 4'h0;
    nxt = 3;
    wd  = RR_EN ? (rr_last == 1'b0) : 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("rr_i_ready", i_ready, (c == nxt) && !wd);
      chk("rr_d_ready", d_ready, (c == nxt) && wd);
      if (c == nxt) begin
        if (wd) begin
          exp_d_rd = ref_read(32'h600); d_known = 1'b1;
        end else begin
          exp_i_rd = ref_read(32'h500);
        end
        rr_last = wd;
        if (c == 15) begin
          i_req = 1'b0; d_req = 1'b0;
        end
        nxt += 4;
        wd = RR_EN ? (rr_last == 1'b0) : 1'b1;
      end
      chk("rr_i_rdata", i_rdata, exp_i_rd);
      chk("rr_d_rdata", d_rdata, exp_d_rd);
    end

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      ri = $urandom_range(0, 1);
      rd = $urandom_range(0, 1);
      if (!ri && !rd) rd = 1'b1;
      pool_a = 32'h1000 + 4 * $urandom_range(0, 7);
      episode(ri, rd, 1'($urandom_range(0, 1)),
              32'h1000 + 4 * $urandom_range(0, 7), pool_a,
              $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    // reset while waiting for the response, late rvalid afterwards
    gnt_dly = 0; rsp_dly = 100;
    i_req = 1'b1; i_addr = 32'h700;
    @(negedge clk);
    chk("rst_pre_mem_req", mem_req, 1);
    @(negedge clk);
    chk("rst_wait_rsp", mem_req, 0);
    reset = 1'b1; mem_flush = 1'b1; i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0; mem_flush = 1'b0; inject_rv = 1'b1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    inject_rv = 1'b0;
    chk("rst_rv_i_ready", i_ready, 0);
    chk("rst_rv_mem_req", mem_req, 0);
    @(negedge clk);
    chk_all_zero("rst_late_rv");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
